// File: rtl/complex_pkg.sv
// Shared definitions for the complex multiply / accumulate datapath.
package complex_pkg;

    localparam int unsigned IN_W_DEF      = 16;
    localparam int unsigned FRAME_LEN_DEF = 8;

    // Accumulator width that cannot overflow when summing frame_len inputs of in_w bits.
    function automatic int unsigned calc_out_w(input int unsigned in_w, input int unsigned frame_len);
        return in_w + $clog2(frame_len);
    endfunction

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/complex_frame_accumulator_if.sv
// Product stream in, frame sums out.
interface complex_frame_accumulator_if
    import complex_pkg::*;
#(
    parameter int unsigned IN_W      = IN_W_DEF,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned OUT_W     = calc_out_w(IN_W, FRAME_LEN)
) ();

    localparam int unsigned CNT_W = $clog2(FRAME_LEN) + 1;

    logic signed [IN_W-1:0]  Re_in;
    logic signed [IN_W-1:0]  Im_in;
    logic        [1:0]       data_valid_in;
    logic                    flush;
    logic signed [OUT_W-1:0] Re_out;
    logic signed [OUT_W-1:0] Im_out;
    logic        [CNT_W-1:0] count_out;
    logic                    data_valid_out;

    modport master (
        output Re_in, Im_in, data_valid_in, flush,
        input  Re_out, Im_out, count_out, data_valid_out
    );

    modport slave (
        input  Re_in, Im_in, data_valid_in, flush,
        output Re_out, Im_out, count_out, data_valid_out
    );

endinterface

// File: rtl/complex_frame_accumulator_acc_lane.sv
// One signed accumulator lane: adds samples, dumps the sum to an output register on close.
module acc_lane #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    add_en,
    input  logic                    close,
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] sum_out
);

    logic signed [OUT_W-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0] sum_q, sum_d;
    logic signed [OUT_W-1:0] din_ext_c;
    logic signed [OUT_W-1:0] total_c;

    // Sum including this cycle's sample; on close it goes out and the accumulator restarts at 0.
    always_comb begin
        acc_d     = acc_q;
        sum_d     = sum_q;
        din_ext_c = {{(OUT_W-IN_W){din[IN_W-1]}}, din};
        total_c   = acc_q + (add_en ? din_ext_c : '0);
        if (close) begin
            sum_d = total_c;
            acc_d = '0;
        end else begin
            acc_d = total_c;
        end
    end

    // Accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    assign sum_out = sum_q;

endmodule

// File: rtl/complex_frame_accumulator.sv
// Sums FRAME_LEN valid complex products (or fewer on flush) into one registered result.
module complex_frame_accumulator
    import complex_pkg::*;
#(
    parameter int unsigned IN_W      = IN_W_DEF,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned OUT_W     = calc_out_w(IN_W, FRAME_LEN)
) (
    input  logic                         clk,
    input  logic                         rst,
    complex_frame_accumulator_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN) + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_out_q, count_out_d;
    logic             valid_q, valid_d;
    logic             accept_c;
    logic             close_c;
    logic [CNT_W-1:0] count_inc_c;
    logic             unused_dv_c;

    // Upper valid bit from the multiplier carries no meaning here.
    assign unused_dv_c = bus.data_valid_in[1];

    // Frame counter, close detection and result strobe.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        count_out_d = count_out_q;
        valid_d     = 1'b0;
        accept_c    = bus.data_valid_in[0];
        count_inc_c = count_q + CNT_W'(accept_c);
        close_c     = (accept_c && (count_inc_c == CNT_W'(FRAME_LEN))) ||
                      (bus.flush && (accept_c || (state_q == ST_ACCUM)));
        if (close_c) begin
            count_out_d = count_inc_c;
            valid_d     = 1'b1;
            count_d     = '0;
            state_d     = ST_EMPTY;
        end else begin
            count_d = count_inc_c;
            state_d = (count_inc_c != '0) ? ST_ACCUM : ST_EMPTY;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            count_q     <= '0;
            count_out_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            count_out_q <= count_out_d;
            valid_q     <= valid_d;
        end
    end

    acc_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane_re (
        .clk     (clk),
        .rst     (rst),
        .add_en  (accept_c),
        .close   (close_c),
        .din     (bus.Re_in),
        .sum_out (bus.Re_out)
    );

    acc_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane_im (
        .clk     (clk),
        .rst     (rst),
        .add_en  (accept_c),
        .close   (close_c),
        .din     (bus.Im_in),
        .sum_out (bus.Im_out)
    );

    assign bus.count_out      = count_out_q;
    assign bus.data_valid_out = valid_q;

endmodule

// File: tb/tb_complex_frame_accumulator.sv
// Bench for complex_frame_accumulator: per-cycle stimulus table, expected frames via scoreboard.
module tb_complex_frame_accumulator;

    localparam int unsigned IN_W      = 16;
    localparam int unsigned FRAME_LEN = 8;

    logic clk;
    logic rst;

    complex_frame_accumulator_if #(.IN_W(IN_W), .FRAME_LEN(FRAME_LEN)) bus ();

    complex_frame_accumulator #(.IN_W(IN_W), .FRAME_LEN(FRAME_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] v;
        logic       fl;
        int         re;
        int         im;
        logic       close;
        int         ere;
        int         eim;
        int         ecnt;
    } vec_t;

    typedef struct {
        longint due;
        longint re;
        longint im;
        longint cnt;
    } exp_t;

    vec_t   vecs[$];
    exp_t   sb[$];
    longint cyc = 0;
    int     passed = 0;
    int     total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Every output pulse must match the oldest outstanding expected frame.
    always @(negedge clk) begin
        if (bus.data_valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.due);
                check("re_out", longint'(bus.Re_out), e.re);
                check("im_out", longint'(bus.Im_out), e.im);
                check("count_out", longint'(bus.count_out), e.cnt);
            end
        end
    end

    task automatic add(input logic r, input logic [1:0] v, input logic fl, input int re, input int im,
                       input logic close, input int ere, input int eim, input int ecnt);
        vec_t t;
        t.rst = r; t.v = v; t.fl = fl; t.re = re; t.im = im;
        t.close = close; t.ere = ere; t.eim = eim; t.ecnt = ecnt;
        vecs.push_back(t);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 2'b00, 1'b0, 0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            @(negedge clk);
            rst               = vecs[i].rst;
            bus.data_valid_in = vecs[i].v;
            bus.flush         = vecs[i].fl;
            bus.Re_in         = IN_W'(vecs[i].re);
            bus.Im_in         = IN_W'(vecs[i].im);
            if (vecs[i].close) begin
                exp_t e;
                e.due = cyc + 1; e.re = vecs[i].ere; e.im = vecs[i].eim; e.cnt = vecs[i].ecnt;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        rst = 1'b0; bus.data_valid_in = 2'b00; bus.flush = 1'b0;
        bus.Re_in = '0; bus.Im_in = '0;
        vecs.delete();
    endtask

    initial begin
        rst = 1'b1;
        bus.data_valid_in = 2'b01; bus.flush = 1'b0;
        bus.Re_in = 16'sd5; bus.Im_in = 16'sd7;

        // Reset held two cycles with valid samples present.
        add(1'b1, 2'b01, 1'b0, 5, 7, 1'b0, 0, 0, 0);
        add(1'b1, 2'b01, 1'b1, 5, 7, 1'b0, 0, 0, 0);
        run_vecs();
        check("rst_re", longint'(bus.Re_out), 0);
        check("rst_im", longint'(bus.Im_out), 0);
        check("rst_cnt", longint'(bus.count_out), 0);
        check("rst_valid", longint'(bus.data_valid_out), 0);

        // Full frame of 8+6i.
        for (int i = 0; i < 7; i++) add(1'b0, 2'b01, 1'b0, 8, 6, 1'b0, 0, 0, 0);
        add(1'b0, 2'b01, 1'b0, 8, 6, 1'b1, 64, 48, 8);
        idle(2);

        // Gapped samples; bit 1 alone must not count as valid; then flush, then flush while empty.
        add(1'b0, 2'b01, 1'b0, 8, 6, 1'b0, 0, 0, 0);
        add(1'b0, 2'b10, 1'b0, 100, 100, 1'b0, 0, 0, 0);
        add(1'b0, 2'b01, 1'b0, 3, 4, 1'b0, 0, 0, 0);
        idle(2);
        add(1'b0, 2'b01, 1'b0, 0, 2, 1'b0, 0, 0, 0);
        idle(1);
        add(1'b0, 2'b11, 1'b0, -3, 4, 1'b0, 0, 0, 0);
        idle(1);
        add(1'b0, 2'b00, 1'b1, 0, 0, 1'b1, 8, 16, 4);
        idle(1);
        add(1'b0, 2'b00, 1'b1, 0, 0, 1'b0, 0, 0, 0);
        idle(3);
        run_vecs();
        check("hold_re", longint'(bus.Re_out), 8);
        check("hold_im", longint'(bus.Im_out), 16);
        check("hold_cnt", longint'(bus.count_out), 4);
        check("hold_valid", longint'(bus.data_valid_out), 0);

        // Extremes: no wrap at the negative limit.
        for (int i = 0; i < 7; i++) add(1'b0, 2'b01, 1'b0, -32768, 32767, 1'b0, 0, 0, 0);
        add(1'b0, 2'b01, 1'b0, -32768, 32767, 1'b1, -262144, 262136, 8);
        idle(2);

        // Back-to-back frames k = 1..16.
        for (int k = 1; k <= 16; k++) begin
            if (k == 8)       add(1'b0, 2'b01, 1'b0, k, 0, 1'b1, 36, 0, 8);
            else if (k == 16) add(1'b0, 2'b01, 1'b0, k, 0, 1'b1, 100, 0, 8);
            else              add(1'b0, 2'b01, 1'b0, k, 0, 1'b0, 0, 0, 0);
        end
        idle(2);

        // Mid-frame reset discards the partial frame and the sample in the reset cycle.
        for (int i = 0; i < 5; i++) add(1'b0, 2'b01, 1'b0, 1, 1, 1'b0, 0, 0, 0);
        add(1'b1, 2'b01, 1'b0, 1, 1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(1'b0, 2'b01, 1'b0, 2, -1, 1'b0, 0, 0, 0);
        add(1'b0, 2'b01, 1'b0, 2, -1, 1'b1, 16, -8, 8);
        idle(2);

        // Flush together with a valid sample mid-frame, then in EMPTY.
        for (int i = 0; i < 3; i++) add(1'b0, 2'b01, 1'b0, 1, 0, 1'b0, 0, 0, 0);
        add(1'b0, 2'b01, 1'b1, 5, 0, 1'b1, 8, 0, 4);
        add(1'b0, 2'b01, 1'b1, 7, -2, 1'b1, 7, -2, 1);
        idle(4);
        run_vecs();

        repeat (2) @(negedge clk);
        check("scoreboard_drained", longint'(sb.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/complex_frame_accumulator.md
# complex_frame_accumulator

Downstream stage of `Complex_Multiplier`. It takes the multiplier's stream of signed complex products (`Re_out`/`Im_out`/`data_valid_out`) and sums `FRAME_LEN` valid products into one complex sum, forming a complex dot product or correlation over a frame. It emits one registered result per frame, or per early `flush`, with a one-cycle valid pulse.

## Interface
- `IN_W`, default 16: signed width of each incoming real/imag product.
- `FRAME_LEN`, default 8: valid products per frame, ≥2.
- `OUT_W`, default `IN_W + $clog2(FRAME_LEN)` (19): accumulator and output width. Overflow is impossible by construction.
- `clk` input, 1: rising-edge clock.
- `rst` input, 1: reset, synchronous, active-high. The block has one clock.
- `Re_in` input, `IN_W` signed: real part of the product (multiplier `Re_out`).
- `Im_in` input, `IN_W` signed: imaginary part of the product (multiplier `Im_out`).
- `data_valid_in` input, 2: multiplier valid. Only bit 0 is used (1 = sample valid); bit 1 is ignored.
- `flush` input, 1: closes the current frame early.
- `Re_out` output, `OUT_W` signed: frame real sum.
- `Im_out` output, `OUT_W` signed: frame imaginary sum.
- `count_out` output, `$clog2(FRAME_LEN)+1`: number of samples summed in the emitted frame.
- `data_valid_out` output, 1: one-cycle result strobe.

## Operation
- States:
  - `EMPTY`: count = 0.
  - `ACCUM`: 0 < count < `FRAME_LEN`.
- Accepted sample: `data_valid_in[0]=1`. Inputs are sign-extended to `OUT_W` and added to `acc_re`/`acc_im`, and count increments.
- Frame close fires when either condition holds:
  - an accepted sample makes count reach `FRAME_LEN`, or
  - `flush=1` while count > 0 after including any sample accepted in the same cycle.
- On close:
  - outputs load the final sums, which include the closing sample;
  - `count_out` gets the final count;
  - `data_valid_out=1`;
  - accumulators and count clear;
  - state goes to `EMPTY`.
- `flush` in `EMPTY` with no valid sample: ignored. No output pulse, nothing changes.
- `flush` in `EMPTY` together with a valid sample: emits a 1-sample frame.
- Back-to-back frames: the sample accepted in the cycle after a close starts the new frame. There is no dead cycle and no sample is dropped.
- Outputs hold their last frame value until the next close. Only `data_valid_out` returns to 0.
- Arithmetic: two's complement, full precision, no rounding or saturation.

## Timing
- Latency: the result appears on the clock edge that registers the closing sample. `data_valid_out` is high in the cycle after the closing input cycle.
- The multiplier's own pipeline latency is upstream and does not matter here: the block reacts only to `data_valid_in[0]`.
- Valid samples may arrive every cycle, with arbitrary gaps between them.
- Reset values: `Re_out=0`, `Im_out=0`, `count_out=0`, `data_valid_out=0`, accumulators 0, count 0, state `EMPTY`.
- `rst` asserted mid-frame: the partial frame is discarded with no output pulse. A sample presented in the reset cycle is dropped. Accumulation restarts with the first valid sample after `rst` deasserts.
- `rst` has priority over `flush` and valid.

## Structure
- Shared package `complex_pkg`:
  - default `IN_W`/`FRAME_LEN`;
  - an `OUT_W` calculation function;
  - the state encoding constants `ST_EMPTY`/`ST_ACCUM`.
  - The multiplier and later stages reuse this package.
- One natural sub-module, `acc_lane`: a single signed accumulator with load/clear/add and an output register. It is instantiated twice (re, im).
- The top level holds the counter, state, close logic and valid strobe.

## Test plan
- Reset: hold `rst` 2 cycles with valid samples present → all outputs 0, no `data_valid_out`.
- Full frame: 8 consecutive products 8+6i → one pulse with `Re_out=64`, `Im_out=48`, `count_out=8`.
- Gapped samples plus flush: products 8+6i, 3+4i, 0+2i, −3+4i with idle cycles between them, then `flush` → `Re_out=8`, `Im_out=16`, `count_out=4`. A `flush` issued next while `EMPTY` produces no pulse.
- Extremes: 8 × (−32768 + 32767i) → `Re_out=−262144`, `Im_out=262136`, with no wrap.
- Back-to-back frames: 16 continuous samples of value k+0i for k=1..16 → pulses 8 cycles apart with `Re_out` 36 then 100. The second frame loses no samples.
- Mid-frame reset: 5 samples of 1+1i, then `rst`, then 8 samples of 2−1i → a single pulse with `Re_out=16`, `Im_out=−8`.
- Flush together with a valid sample: 3 samples of 1+0i, then 5+0i with `flush` in the same cycle → `Re_out=8`, `count_out=4`.
